// File: rtl/fetch_prefetch_unit_pkg.sv
// Shared definitions for the fetch front-end.
// Holds the default datapath parameters, the fetch FSM state encoding and
// the NOP encoding that decode substitutes while no instruction is valid.
package fetch_prefetch_unit_pkg;

   localparam int unsigned FETCH_XLEN        = 32;
   localparam int unsigned FETCH_QUEUE_DEPTH = 4;
   localparam logic [31:0] FETCH_RESET_PC    = 32'h0000_0000;
   localparam logic [31:0] FETCH_NOP         = 32'h0000_0013;

   typedef enum logic [1:0] {
      FETCH_IDLE    = 2'd0,
      FETCH_WAIT    = 2'd1,
      FETCH_DISCARD = 2'd2
   } fetch_state_e;

endpackage

// File: rtl/fetch_prefetch_unit_queue.sv
// Prefetch queue: synchronous FIFO holding {pc, instruction} entries.
// Ports:
//   clk, reset          clock, async active-low reset
//   flush               empties the queue; wins over push and pop
//   push, push_data     enqueue one entry (caller guarantees not full)
//   pop                 drop the head entry (ignored when empty)
//   head                head entry, zero when the queue is empty
//   count               occupied entries
module fetch_prefetch_unit_queue #(
   parameter  int unsigned WIDTH = 64,
   parameter  int unsigned DEPTH = 4,
   localparam int unsigned PW    = $clog2(DEPTH),
   localparam int unsigned CW    = PW + 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             flush,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head,
   output logic [CW-1:0]    count
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign do_push = push & ~flush;
   assign do_pop  = pop & ~flush & (count != '0);
   assign head    = (count != '0) ? mem[rd_ptr] : '0;

   // Pointers wrap naturally because DEPTH is a power of two
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
         if (do_push && !do_pop)      count <= count + CW'(1);
         else if (!do_push && do_pop) count <= count - CW'(1);
      end
   end

   // Storage needs no reset: head is masked while the queue is empty
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

endmodule

// File: rtl/fetch_prefetch_unit.sv
// Fetch front-end: owns the PC, issues one instruction-cache request at a
// time, buffers responses in the prefetch queue and presents the head to
// decode. A redirect reloads the PC, flushes the queue and drops any stale
// in-flight response.
// Ports:
//   clk, reset                     clock, async active-low reset
//   redirect_valid, redirect_pc    branch/exception redirect (target word-aligned here)
//   ic_req_valid/addr/ready        cache request handshake
//   ic_resp_valid, ic_resp_data    cache response, one instruction
//   inst_valid/ready, inst_pc/data decode handshake on the queue head
//   queue_count                    occupied queue entries
module fetch_prefetch_unit
   import fetch_prefetch_unit_pkg::*;
#(
   parameter  int unsigned     XLEN        = FETCH_XLEN,
   parameter  int unsigned     QUEUE_DEPTH = FETCH_QUEUE_DEPTH,
   parameter  logic [XLEN-1:0] RESET_PC    = XLEN'(FETCH_RESET_PC),
   localparam int unsigned     CW          = $clog2(QUEUE_DEPTH) + 1
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc,
   output logic            ic_req_valid,
   output logic [XLEN-1:0] ic_req_addr,
   input  logic            ic_req_ready,
   input  logic            ic_resp_valid,
   input  logic [XLEN-1:0] ic_resp_data,
   output logic            inst_valid,
   input  logic            inst_ready,
   output logic [XLEN-1:0] inst_pc,
   output logic [XLEN-1:0] inst_data,
   output logic [CW-1:0]   queue_count
);

   fetch_state_e      state;
   fetch_state_e      state_next;
   logic [XLEN-1:0]   pc;
   logic [XLEN-1:0]   req_pc;
   logic              fetch_en;
   logic              req_fire;
   logic              enq;
   logic              deq;
   logic [2*XLEN-1:0] head;
   logic              redirect_low_unused;

   assign redirect_low_unused = ^redirect_pc[1:0];
   assign req_fire            = ic_req_valid & ic_req_ready;
   assign deq                 = inst_valid & inst_ready & ~redirect_valid;
   assign inst_valid          = (queue_count != '0);
   assign {inst_pc, inst_data} = head;
   assign ic_req_addr         = pc;

   // State register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= FETCH_IDLE;
      else        state <= state_next;
   end

   // Next state, request and enqueue decisions.
   // Requests only leave IDLE, so the in-flight slot reservation reduces to
   // count < QUEUE_DEPTH: a response can never meet a full queue.
   always_comb begin
      state_next   = state;
      ic_req_valid = 1'b0;
      enq          = 1'b0;
      case (state)
         FETCH_IDLE: begin
            ic_req_valid = fetch_en & ~redirect_valid &
                           (queue_count < CW'(QUEUE_DEPTH));
            if (ic_req_valid && ic_req_ready) state_next = FETCH_WAIT;
         end
         FETCH_WAIT: begin
            if (ic_resp_valid) begin
               enq        = ~redirect_valid;
               state_next = FETCH_IDLE;
            end else if (redirect_valid) begin
               state_next = FETCH_DISCARD;
            end
         end
         FETCH_DISCARD: begin
            if (ic_resp_valid) state_next = FETCH_IDLE;
         end
         default: state_next = FETCH_IDLE;
      endcase
   end

   // PC, in-flight request PC, and a request enable held off while in reset
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pc       <= RESET_PC;
         req_pc   <= '0;
         fetch_en <= 1'b0;
      end else begin
         fetch_en <= 1'b1;
         if (redirect_valid)  pc <= {redirect_pc[XLEN-1:2], 2'b00};
         else if (req_fire)   pc <= pc + XLEN'(4);
         if (req_fire) req_pc <= pc;
      end
   end

   fetch_prefetch_unit_queue #(
      .WIDTH (2 * XLEN),
      .DEPTH (QUEUE_DEPTH)
   ) u_queue (
      .clk       (clk),
      .reset     (reset),
      .flush     (redirect_valid),
      .push      (enq),
      .push_data ({req_pc, ic_resp_data}),
      .pop       (deq),
      .head      (head),
      .count     (queue_count)
   );

endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// Self-checking bench for fetch_prefetch_unit (XLEN=32, QUEUE_DEPTH=4, RESET_PC=0).
module tb_fetch_prefetch_unit;

   logic        clk;
   logic        reset;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        ic_req_valid;
   logic [31:0] ic_req_addr;
   logic        ic_req_ready;
   logic        ic_resp_valid;
   logic [31:0] ic_resp_data;
   logic        inst_valid;
   wire         inst_ready;
   logic [31:0] inst_pc;
   logic [31:0] inst_data;
   logic [2:0]  queue_count;

   // cache model / decode model controls (written by the main thread only)
   int   lat;
   int   grant_total;
   logic sync_mode;
   logic ready_lvl;

   // cache model state (written by the model thread only)
   int          granted;
   logic        pend;
   int          cnt;
   logic [31:0] pend_addr;

   // observed decode transfers (written by the model thread only)
   logic [31:0] obs_pc   [256];
   logic [31:0] obs_data [256];
   time         obs_t    [256];
   int          obs_n;

   // scoreboard
   logic [31:0] exp_q [$];
   int          rd_n;
   int          n_pass;
   int          n_total;

   typedef struct {
      logic [31:0] target;
      logic [31:0] exp_addr;
   } redir_vec_t;
   redir_vec_t vecs [4];

   assign inst_ready = sync_mode ? ic_resp_valid : ready_lvl;

   fetch_prefetch_unit dut (
      .clk            (clk),
      .reset          (reset),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .ic_req_valid   (ic_req_valid),
      .ic_req_addr    (ic_req_addr),
      .ic_req_ready   (ic_req_ready),
      .ic_resp_valid  (ic_resp_valid),
      .ic_resp_data   (ic_resp_data),
      .inst_valid     (inst_valid),
      .inst_ready     (inst_ready),
      .inst_pc        (inst_pc),
      .inst_data      (inst_data),
      .queue_count    (queue_count)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [31:0] fdata(input logic [31:0] a);
      return a ^ 32'h1357_9BDF;
   endfunction

   // Cache model plus decode-side observer, evaluated mid-cycle
   initial begin
      ic_req_ready  = 1'b0;
      ic_resp_valid = 1'b0;
      ic_resp_data  = '0;
      granted       = 0;
      pend          = 1'b0;
      cnt           = 0;
      pend_addr     = '0;
      obs_n         = 0;
      forever begin
         @(negedge clk);
         ic_resp_valid = 1'b0;
         if (pend) begin
            if (cnt <= 1) begin
               ic_resp_valid = 1'b1;
               ic_resp_data  = fdata(pend_addr);
               pend          = 1'b0;
            end else begin
               cnt = cnt - 1;
            end
         end
         ic_req_ready = (granted < grant_total);
         if (ic_req_valid && ic_req_ready) begin
            pend      = 1'b1;
            cnt       = lat;
            pend_addr = ic_req_addr;
            granted   = granted + 1;
         end
         if (inst_valid && (sync_mode ? ic_resp_valid : ready_lvl) && !redirect_valid
             && obs_n < 256) begin
            obs_pc[obs_n]   = inst_pc;
            obs_data[obs_n] = inst_data;
            obs_t[obs_n]    = $time;
            obs_n           = obs_n + 1;
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total = n_total + 1;
      if (act === exp) n_pass = n_pass + 1;
      else $display("FAIL %s: actual=%h required=%h", name, act, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_redirect(input logic [31:0] addr);
      redirect_pc    = addr;
      redirect_valid = 1'b1;
      tick();
      redirect_valid = 1'b0;
      #1;
   endtask

   // grant n cache requests and expect n sequential instructions from base
   task automatic expect_seq(input logic [31:0] base, input int n);
      for (int i = 0; i < n; i++) exp_q.push_back(base + 32'(i * 4));
      grant_total = grant_total + n;
   endtask

   task automatic wait_grant(input string name);
      int c = 0;
      while (granted != grant_total && c < 50) begin
         tick();
         c++;
      end
      chk({name, " grant"}, 32'(granted), 32'(grant_total));
   endtask

   task automatic wait_count(input string name, input logic [2:0] target);
      int c = 0;
      while (queue_count !== target && c < 60) begin
         tick();
         c++;
      end
      chk({name, " count"}, 32'(queue_count), 32'(target));
   endtask

   task automatic drain(input string name);
      int c = 0;
      logic [31:0] e;
      while ((obs_n - rd_n) < exp_q.size() && c < 200) begin
         tick();
         c++;
      end
      repeat (4) tick();
      chk({name, " n_out"}, 32'(obs_n - rd_n), 32'(exp_q.size()));
      while (exp_q.size() > 0 && rd_n < obs_n) begin
         e = exp_q.pop_front();
         chk({name, " pc"},   obs_pc[rd_n],   e);
         chk({name, " data"}, obs_data[rd_n], fdata(e));
         rd_n++;
      end
      exp_q.delete();
      rd_n = obs_n;
   endtask

   initial begin
      int base;
      vecs[0] = '{32'h0000_0103, 32'h0000_0100};
      vecs[1] = '{32'h0000_02A6, 32'h0000_02A4};
      vecs[2] = '{32'h0000_0008, 32'h0000_0008};
      vecs[3] = '{32'hFFFF_FFFD, 32'hFFFF_FFFC};

      n_pass = 0; n_total = 0; rd_n = 0;
      lat = 1; grant_total = 0; sync_mode = 1'b0; ready_lvl = 1'b0;
      reset = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;

      // reset state
      repeat (2) tick();
      chk("rst ic_req_valid", 32'(ic_req_valid), 32'd0);
      chk("rst inst_valid",   32'(inst_valid),   32'd0);
      chk("rst queue_count",  32'(queue_count),  32'd0);
      chk("rst inst_pc",      inst_pc,           32'h0);
      chk("rst inst_data",    inst_data,         32'h0);
      reset = 1'b1;
      #1;
      chk("rst ic_req_addr",  ic_req_addr,       32'h0);

      // 1: streaming fetch, one instruction per two cycles
      ready_lvl = 1'b1;
      base = obs_n;
      expect_seq(32'h0, 4);
      drain("t1");
      chk("t1 rate a", 32'(obs_t[base+1] - obs_t[base]),   32'd20);
      chk("t1 rate b", 32'(obs_t[base+3] - obs_t[base+2]), 32'd20);

      // 2: decode stall fills the queue, then fetching resumes
      ready_lvl = 1'b0;
      do_redirect(32'h0);
      expect_seq(32'h0, 6);
      wait_count("t2 fill", 3'd4);
      repeat (3) tick();
      chk("t2 full count",   32'(queue_count),  32'd4);
      chk("t2 full req",     32'(ic_req_valid), 32'd0);
      chk("t2 head pc",      inst_pc,           32'h0);
      chk("t2 head data",    inst_data,         fdata(32'h0));
      ready_lvl = 1'b1;
      tick();
      chk("t2 resume req",   32'(ic_req_valid), 32'd1);
      chk("t2 resume addr",  ic_req_addr,       32'h10);
      drain("t2");

      // 3: redirect during WAIT, stale response two cycles later
      lat = 2;
      grant_total = grant_total + 1;
      wait_grant("t3");
      do_redirect(32'h100);
      chk("t3 discard count", 32'(queue_count),  32'd0);
      chk("t3 discard req",   32'(ic_req_valid), 32'd0);
      tick();
      chk("t3 idle req",      32'(ic_req_valid), 32'd1);
      chk("t3 idle addr",     ic_req_addr,       32'h100);
      chk("t3 inst_valid",    32'(inst_valid),   32'd0);
      lat = 1;
      expect_seq(32'h100, 2);
      drain("t3");

      // 4: redirect and response in the same cycle, misaligned target
      grant_total = grant_total + 1;
      wait_grant("t4");
      do_redirect(32'h103);
      chk("t4 count",      32'(queue_count),  32'd0);
      chk("t4 req",        32'(ic_req_valid), 32'd1);
      chk("t4 addr",       ic_req_addr,       32'h100);
      tick();
      chk("t4 inst_valid", 32'(inst_valid),   32'd0);
      expect_seq(32'h100, 1);
      drain("t4");

      // redirect alignment table
      for (int i = 0; i < 4; i++) begin
         do_redirect(vecs[i].target);
         chk($sformatf("vec%0d addr", i),  ic_req_addr,       vecs[i].exp_addr);
         chk($sformatf("vec%0d req", i),   32'(ic_req_valid), 32'd1);
         chk($sformatf("vec%0d count", i), 32'(queue_count),  32'd0);
      end
      // PC wraps from FFFF_FFFC to 0
      expect_seq(32'hFFFF_FFFC, 2);
      drain("wrap");

      // 5: enqueue and dequeue in the same cycle at count=2, pointer wrap
      ready_lvl = 1'b0;
      do_redirect(32'h200);
      expect_seq(32'h200, 14);
      wait_count("t5 pre", 3'd2);
      sync_mode = 1'b1;
      for (int i = 0; i < 30; i++) begin
         tick();
         chk($sformatf("t5 hold%0d", i), 32'(queue_count), 32'd2);
      end
      chk("t5 granted", 32'(granted), 32'(grant_total));
      sync_mode = 1'b0;
      ready_lvl = 1'b1;
      drain("t5");

      // 6: reset mid-WAIT, late response never enqueued
      ready_lvl = 1'b0;
      do_redirect(32'h300);
      grant_total = grant_total + 1;
      wait_grant("t6a");
      tick();
      chk("t6 pre pc", inst_pc, 32'h300);
      lat = 3;
      grant_total = grant_total + 1;
      wait_grant("t6b");
      reset = 1'b0;
      #1;
      chk("t6 rst ic_req_valid", 32'(ic_req_valid), 32'd0);
      chk("t6 rst inst_valid",   32'(inst_valid),   32'd0);
      chk("t6 rst queue_count",  32'(queue_count),  32'd0);
      chk("t6 rst inst_pc",      inst_pc,           32'h0);
      chk("t6 rst inst_data",    inst_data,         32'h0);
      tick();
      reset = 1'b1;
      repeat (3) tick();
      chk("t6 post count", 32'(queue_count),  32'd0);
      chk("t6 post valid", 32'(inst_valid),   32'd0);
      chk("t6 post req",   32'(ic_req_valid), 32'd1);
      chk("t6 post addr",  ic_req_addr,       32'h0);
      lat = 1;
      ready_lvl = 1'b1;
      expect_seq(32'h0, 2);
      drain("t6");

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
